// File: rtl/ili_spi_tx.sv
// ili_spi_tx: ILI9341 4-wire SPI write engine, one DW-bit word per request, mode 0, MSB first.
module ili_spi_tx #(
   parameter int DW      = 8,
   parameter int CLK_DIV = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_send_comm_ena,
   input  logic          i_dc,
   input  logic [DW-1:0] i_command,
   output logic          o_command_sent,
   output logic          o_busy,
   output logic          o_spi_csx,
   output logic          o_spi_dcx,
   output logic          o_spi_scl,
   output logic          o_spi_sda
);
   localparam int DIVW = $clog2(CLK_DIV + 1);
   localparam int BW   = $clog2(DW);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(DW - 1);
   typedef enum logic [2:0] {IDLE, SETUP, SCL_HI, SCL_LO, HOLD, DONE} state_t;
   state_t          state_q, state_d;
   logic [DIVW-1:0] div_q, div_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [DW-1:0]   shift_q, shift_d;
   logic            dc_q, dc_d, csx_q, csx_d, scl_q, scl_d, sda_q, sda_d;
   logic            busy_q, busy_d, sent_q, sent_d;
   logic            phase_end, accept, advance;
   assign phase_end = div_q == DIV_LAST;
   assign accept    = state_q == IDLE && i_send_comm_ena;
   assign advance   = state_q == SCL_HI && phase_end && bit_q != '0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept    ? SETUP  : IDLE;
         SETUP:   state_d = phase_end ? SCL_HI : SETUP;
         SCL_HI:  state_d = !phase_end ? SCL_HI : (bit_q == '0 ? HOLD : SCL_LO);
         SCL_LO:  state_d = phase_end ? SCL_HI : SCL_LO;
         HOLD:    state_d = phase_end ? DONE   : HOLD;
         default: state_d = IDLE;
      endcase
   end
   // Outputs are registered from the next state so pins change on the same edge as the FSM.
   always_comb begin
      div_d   = (phase_end || state_q == IDLE || state_q == DONE) ? '0 : div_q + 1'b1;
      bit_d   = state_q == SETUP ? BIT_LAST : (advance ? bit_q - 1'b1 : bit_q);
      shift_d = accept ? i_command : (advance ? {shift_q[DW-2:0], 1'b0} : shift_q);
      dc_d    = accept ? i_dc : dc_q;
      csx_d   = state_d inside {IDLE, DONE};
      scl_d   = state_d == SCL_HI;
      sda_d   = (state_d == SETUP || state_d == SCL_LO) ? shift_d[DW-1] : sda_q;
      busy_d  = state_d != IDLE;
      sent_d  = state_d == DONE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dc_q    <= 1'b0;
         csx_q   <= 1'b1;
         scl_q   <= 1'b0;
         sda_q   <= 1'b0;
         busy_q  <= 1'b0;
         sent_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dc_q    <= dc_d;
         csx_q   <= csx_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
         busy_q  <= busy_d;
         sent_q  <= sent_d;
      end
   end
   assign o_command_sent = sent_q;
   assign o_busy         = busy_q;
   assign o_spi_csx      = csx_q;
   assign o_spi_dcx      = dc_q;
   assign o_spi_scl      = scl_q;
   assign o_spi_sda      = sda_q;
endmodule

// File: tb/tb_ili_spi_tx.sv
// tb_ili_spi_tx: scoreboard bench for ili_spi_tx, one instance at CLK_DIV=4 and one at CLK_DIV=1.
module tb_ili_spi_tx;
   localparam int DW = 8;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    ena = '0;
   logic          dc  = 1'b0;
   logic [DW-1:0] cmd = '0;
   logic [1:0]    sent, busy, csx, dcx, scl, sda;
   int            vectors = 0, miscompares = 0, cyc = 0;
   logic [DW:0]   sb[$];
   logic [DW:0]   exp_w;
   int            done_cnt[2], nrise[2], csx_len[2], hi_len[2], last_hi[2];
   int            busy_cyc[2], last_chg[2], last_rise[2], d;
   logic [DW-1:0] word[2];
   logic          p_csx[2], p_scl[2], p_sda[2], p_busy[2], p_sent[2], dc_at[2];

   always #5 clk = ~clk;

   ili_spi_tx #(.DW(DW), .CLK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .i_send_comm_ena(ena[0]), .i_dc(dc), .i_command(cmd),
      .o_command_sent(sent[0]), .o_busy(busy[0]), .o_spi_csx(csx[0]), .o_spi_dcx(dcx[0]),
      .o_spi_scl(scl[0]), .o_spi_sda(sda[0]));
   ili_spi_tx #(.DW(DW), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .i_send_comm_ena(ena[1]), .i_dc(dc), .i_command(cmd),
      .o_command_sent(sent[1]), .o_busy(busy[1]), .o_spi_csx(csx[1]), .o_spi_dcx(dcx[1]),
      .o_spi_scl(scl[1]), .o_spi_sda(sda[1]));

   initial begin
      for (int k = 0; k < 2; k++) begin
         done_cnt[k] = 0; nrise[k] = 0; csx_len[k] = 0; hi_len[k] = 0; last_hi[k] = 0;
         busy_cyc[k] = 0; last_chg[k] = -1000; last_rise[k] = -1000; word[k] = '0;
         p_csx[k] = 1'b1; p_scl[k] = 1'b0; p_sda[k] = 1'b0; p_busy[k] = 1'b0; p_sent[k] = 1'b0;
         dc_at[k] = 1'b0;
      end
   end

   // Monitor: decodes both SPI buses on the falling clock edge and checks each word against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? 4 : 1;
         if (!rst) begin
            nrise[k] = 0; word[k] = '0; csx_len[k] = 0;
         end else begin
            if (!csx[k]) begin
               if (p_csx[k]) begin
                  dc_at[k] = dcx[k]; last_hi[k] = hi_len[k]; csx_len[k] = 0;
                  nrise[k] = 0; word[k] = '0; last_chg[k] = cyc;
               end else if (sda[k] !== p_sda[k]) begin
                  last_chg[k] = cyc;
                  vectors++;
                  if (cyc - last_rise[k] < d) begin
                     miscompares++;
                     $display("FAIL sda_hold[%0d]: changed %0d cycles after scl rise, need >= %0d", k, cyc - last_rise[k], d);
                  end
               end
               csx_len[k]++;
               vectors++;
               if (dcx[k] !== dc_at[k]) begin
                  miscompares++;
                  $display("FAIL dcx_const[%0d]: got %b, expected %b", k, dcx[k], dc_at[k]);
               end
            end else begin
               if (!p_csx[k]) begin
                  vectors++;
                  if (csx_len[k] != 17 * d) begin
                     miscompares++;
                     $display("FAIL csx_low_len[%0d]: got %0d, expected %0d", k, csx_len[k], 17 * d);
                  end
                  hi_len[k] = 0;
               end
               hi_len[k]++;
            end
            if (scl[k] && !p_scl[k]) begin
               word[k] = {word[k][DW-2:0], sda[k]};
               nrise[k]++;
               last_rise[k] = cyc;
               vectors++;
               if (cyc - last_chg[k] < d) begin
                  miscompares++;
                  $display("FAIL sda_setup[%0d]: stable %0d cycles before scl rise, need >= %0d", k, cyc - last_chg[k], d);
               end
            end
            if (busy[k] && !p_busy[k]) busy_cyc[k] = cyc;
            if (sent[k]) begin
               done_cnt[k]++;
               vectors++;
               if (p_sent[k]) begin
                  miscompares++;
                  $display("FAIL done_width[%0d]: o_command_sent high for more than one cycle", k);
               end
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL sb_empty[%0d]: got word %h with nothing expected", k, {dcx[k], word[k]});
               end else begin
                  exp_w = sb.pop_front();
                  if ({dcx[k], word[k]} !== exp_w) begin
                     miscompares++;
                     $display("FAIL sb_word[%0d]: got dc/word %h, expected %h", k, {dcx[k], word[k]}, exp_w);
                  end
               end
               vectors++;
               if (nrise[k] != DW) begin
                  miscompares++;
                  $display("FAIL scl_rises[%0d]: got %0d, expected %0d", k, nrise[k], DW);
               end
               vectors++;
               if (cyc - busy_cyc[k] != 17 * d) begin
                  miscompares++;
                  $display("FAIL done_latency[%0d]: got %0d, expected %0d", k, cyc - busy_cyc[k], 17 * d);
               end
            end
         end
         p_csx[k] = csx[k]; p_scl[k] = scl[k]; p_sda[k] = sda[k]; p_busy[k] = busy[k]; p_sent[k] = sent[k];
      end
   end

   task automatic pulse(input int k, input logic [DW-1:0] c, input logic f);
      @(negedge clk);
      cmd = c; dc = f; ena[k] = 1'b1;
      sb.push_back({f, c});
      @(negedge clk);
      ena[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int n0);
      int t;
      t = 0;
      while (done_cnt[k] == n0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if ({csx[k], scl[k], sda[k], dcx[k], busy[k], sent[k]} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset[%0d]: got csx/scl/sda/dcx/busy/sent %b, expected 100000", k,
                     {csx[k], scl[k], sda[k], dcx[k], busy[k], sent[k]});
         end
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd_2a();
      int n0;
      n0 = done_cnt[0];
      pulse(0, 8'h2A, 1'b0);
      wait_done(0, n0);
      vectors++;
      if (done_cnt[0] != n0 + 1) begin
         miscompares++;
         $display("FAIL cmd_2a_done: got %0d pulses, expected 1", done_cnt[0] - n0);
      end
   endtask

   task automatic test_data_a5();
      int n0;
      n0 = done_cnt[0];
      pulse(0, 8'hA5, 1'b1);
      wait_done(0, n0);
      vectors++;
      if (done_cnt[0] != n0 + 1) begin
         miscompares++;
         $display("FAIL data_a5_done: got %0d pulses, expected 1", done_cnt[0] - n0);
      end
      vectors++;
      if (dcx[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL dcx_idle_keep: got %b, expected 1", dcx[0]);
      end
   endtask

   task automatic test_back_to_back();
      int n0, seen, t;
      n0 = done_cnt[0]; seen = 0; t = 0;
      @(negedge clk);
      cmd = 8'h2A; dc = 1'b0; ena[0] = 1'b1;
      sb.push_back({1'b0, 8'h2A});
      while (seen < 2 && t < 1000) begin
         @(negedge clk);
         t++;
         if (sent[0]) begin
            seen++;
            if (seen == 1) begin
               cmd = 8'h2B;
               sb.push_back({1'b0, 8'h2B});
            end else ena[0] = 1'b0;
         end
      end
      ena[0] = 1'b0;
      repeat (20) @(negedge clk);
      vectors++;
      if (done_cnt[0] != n0 + 2) begin
         miscompares++;
         $display("FAIL b2b_done: got %0d pulses, expected 2", done_cnt[0] - n0);
      end
      vectors++;
      if (last_hi[0] != 2) begin
         miscompares++;
         $display("FAIL b2b_csx_gap: got %0d high cycles, expected 2", last_hi[0]);
      end
      vectors++;
      if (busy[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: busy got %b, expected 0", busy[0]);
      end
   endtask

   task automatic test_busy_ignore();
      int n0;
      n0 = done_cnt[0];
      pulse(0, 8'h5A, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cmd = 8'hFF; dc = 1'b1; ena[0] = i[0];
      end
      ena[0] = 1'b0;
      wait_done(0, n0);
      repeat (20) @(negedge clk);
      vectors++;
      if (done_cnt[0] != n0 + 1) begin
         miscompares++;
         $display("FAIL busy_ignore_done: got %0d pulses, expected 1", done_cnt[0] - n0);
      end
      vectors++;
      if (busy[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_ignore_idle: busy got %b, expected 0", busy[0]);
      end
   endtask

   task automatic test_reset_mid();
      int n0, t;
      n0 = done_cnt[0]; t = 0;
      pulse(0, 8'hC3, 1'b0);
      while (!(nrise[0] == 4 && scl[0]) && t < 200) begin
         @(negedge clk);
         #2;
         t++;
      end
      vectors++;
      if (nrise[0] != 4 || scl[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_reach: got %0d rises scl %b, expected 4 rises scl 1", nrise[0], scl[0]);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if ({csx[0], scl[0], busy[0], sent[0]} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got csx/scl/busy/sent %b, expected 1000", {csx[0], scl[0], busy[0], sent[0]});
      end
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (done_cnt[0] != n0) begin
         miscompares++;
         $display("FAIL reset_mid_nodone: got %0d pulses, expected 0", done_cnt[0] - n0);
      end
      pulse(0, 8'h96, 1'b1);
      wait_done(0, n0);
      vectors++;
      if (done_cnt[0] != n0 + 1) begin
         miscompares++;
         $display("FAIL reset_mid_resend: got %0d pulses, expected 1", done_cnt[0] - n0);
      end
   endtask

   task automatic test_div1();
      int n0;
      n0 = done_cnt[1];
      pulse(1, 8'h01, 1'b0);
      wait_done(1, n0);
      vectors++;
      if (done_cnt[1] != n0 + 1) begin
         miscompares++;
         $display("FAIL div1_done: got %0d pulses, expected 1", done_cnt[1] - n0);
      end
   endtask

   initial begin
      test_reset();
      test_cmd_2a();
      test_data_a5();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      test_div1();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d words pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ili_spi_tx.md
Name: ili_spi_tx

Overview:
- Serial write engine for the ILI9341 4-wire SPI interface (CSX, DCX, SCL, SDA).
- Sits between the ILI9341 control FSM and the panel pins.
- Responds to the controller's send request (enable plus command/data byte plus D/C flag). Shifts the byte out MSB-first, SPI mode 0.
- Returns a one-cycle done pulse that the controller consumes as its command-sent input.

Parameters:
- DW, 8, width of the transferred word in bits (>=2).
- CLK_DIV, 4, number of clk cycles per SCL half-period (legal range 1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- i_send_comm_ena  input  1  transfer request, level-sampled in IDLE
- i_dc  input  1  D/C select, latched with the word: 0 = command, 1 = parameter/pixel data
- i_command  input  DW  word to transmit, latched at accept
- o_command_sent  output  1  one-cycle pulse when the transfer completes
- o_busy  output  1  high from the accept edge until return to IDLE
- o_spi_csx  output  1  chip select, active low
- o_spi_dcx  output  1  D/C line to panel
- o_spi_scl  output  1  serial clock, idles low
- o_spi_sda  output  1  serial data, MSB first

Behaviour:
- All outputs are registered.
- Reset values (async, immediate): o_spi_csx=1, o_spi_scl=0, o_spi_sda=0, o_spi_dcx=0, o_busy=0, o_command_sent=0, state=IDLE.
- States: IDLE, SETUP, SCL_HI, SCL_LO, HOLD, DONE. Let D = CLK_DIV.
- IDLE:
  - csx=1, scl=0, busy=0.
  - If i_send_comm_ena=1 at a rising edge (accept edge E0): latch i_command into the shift register and i_dc into the DC register, then go to SETUP.
- SETUP (D cycles):
  - csx=0, dcx=latched DC, sda=word[DW-1], scl=0.
  - Bit counter is loaded with DW-1.
  - Then go to SCL_HI.
- SCL_HI (D cycles):
  - scl=1; sda is held stable.
  - At the end of the phase: if the bit counter is 0, go to HOLD. Otherwise decrement the counter, shift left by one, and go to SCL_LO.
- SCL_LO (D cycles): scl=0, sda=next bit, presented at phase start; then go to SCL_HI.
- HOLD (D cycles): scl=0, csx=0, sda is held; then go to DONE.
- DONE (1 cycle): csx=1, o_command_sent=1, busy=1; then go to IDLE.
- Timing:
  - SCL delivers exactly DW rising edges per transfer.
  - Each SDA bit is stable for D cycles before and D cycles after its SCL rising edge.
  - csx is low for exactly (2*DW+1)*D cycles.
  - o_command_sent is high during the cycle that begins at edge E0+(2*DW+1)*D.
  - The next accept can occur no earlier than edge E0+(2*DW+1)*D+2, so csx is high for at least 2 cycles between words.
- dcx is constant for the whole csx-low window. It keeps the last value in IDLE and is reset only by rst.
- Handshake:
  - The requester samples o_command_sent=1 on the same edge at which DONE→IDLE occurs, and updates or deasserts i_send_comm_ena/i_command there. No double send therefore results.
  - i_send_comm_ena, i_command and i_dc are ignored while busy; requests are not queued.
- Reset mid-transfer: the block returns to IDLE asynchronously and csx goes high at once. No o_command_sent pulse is issued and the partial word is discarded.
- CLK_DIV=1 is legal: each phase is 1 cycle.
- Counters: divider width $clog2(CLK_DIV+1); bit counter width $clog2(DW).

Test Plan:
1. DW=8, D=4, i_command=0x2A, i_dc=0 pulsed 1 cycle -> dcx=0; SDA sampled on the 8 SCL rises = 0,0,1,0,1,0,1,0; csx low for 68 cycles; o_command_sent high exactly 1 cycle, 68 cycles after accept.
2. i_command=0xA5, i_dc=1 -> dcx=1 throughout csx-low; bits 1,0,1,0,0,1,0,1; SDA never changes within D cycles of an SCL rise.
3. Requester holds i_send_comm_ena=1 and updates to 0x2B on each o_command_sent -> words 0x2A then 0x2B are sent; exactly 2 done pulses; csx high for exactly 2 cycles between them.
4. i_send_comm_ena toggled with 0xFF while busy -> ignored; only the original word appears on SDA; one done pulse.
5. rst asserted during the 4th SCL high phase -> csx=1, scl=0, busy=0 immediately, no done pulse; the next request after release sends the full word correctly.
6. D=1, i_command=0x01 -> SCL period 2 cycles; csx low for 17 cycles; bits 0,0,0,0,0,0,0,1.
